// File: rtl/sm83_regfile_pkg.sv
// Shared types for the SM83 register file: write-enable vector, selects, IDU controls
// and the registered architectural state vector.
package sm83_pkg;

  typedef logic [7:0] r8_t;

  localparam logic [15:0] RST_PC_DEF = 16'h0000;
  localparam logic [15:0] RST_SP_DEF = 16'hFFFE;

  typedef struct packed {
    logic ir;
    logic ie;
    logic a;
    logic f;
    logic gp8;
    logic gp16;
    logic pc;
    logic sp;
  } reg_wen_vec_t;

  typedef enum logic [2:0] {
    R8_B = 3'd0, R8_C = 3'd1, R8_D = 3'd2, R8_E = 3'd3, R8_H = 3'd4, R8_L = 3'd5
  } gp_r8_sel_t;

  typedef enum logic [1:0] {
    R16_BC = 2'd0, R16_DE = 2'd1, R16_HL = 2'd2
  } gp_r16_sel_t;

  typedef enum logic [1:0] {
    IDU_NONE = 2'd0, IDU_INC = 2'd1, IDU_DEC = 2'd2
  } idu_op_t;

  typedef enum logic [1:0] {
    IDU_PC = 2'd0, IDU_SP = 2'd1, IDU_R16 = 2'd2
  } idu_tgt_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
    logic [3:0] rsvd;
  } flags_t;

  typedef union packed {
    logic [15:0] r16;
    struct packed {
      r8_t msb;
      r8_t lsb;
    } r8;
  } r16_t;

  typedef struct packed {
    r8_t         ir;
    r8_t         ie;
    r8_t         a;
    flags_t      f;
    r16_t        b_c;
    r16_t        d_e;
    r16_t        h_l;
    logic [15:0] pc;
    logic [15:0] sp;
  } reg_vec_t;

  // Read one general-purpose pair; select 3 has no backing pair and reads as zero.
  function automatic logic [15:0] pair_get(input reg_vec_t r, input logic [1:0] s);
    case (s)
      2'd0:    pair_get = r.b_c.r16;
      2'd1:    pair_get = r.d_e.r16;
      2'd2:    pair_get = r.h_l.r16;
      default: pair_get = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sm83_regfile_if.sv
// Write/read bus between decoder/ALU writeback (master) and the register file (slave).
import sm83_pkg::*;

interface sm83_regfile_if;
  reg_wen_vec_t wen_i;
  gp_r8_sel_t   gp8_sel_i;
  gp_r16_sel_t  gp16_sel_i;
  r8_t          wdata8_i;
  flags_t       f_wdata_i;
  logic [15:0]  wdata16_i;
  idu_op_t      idu_op_i;
  idu_tgt_t     idu_tgt_i;
  reg_vec_t     regs_o;
  logic [15:0]  idu_addr_o;
  logic         illegal_o;

  modport master (
    output wen_i, gp8_sel_i, gp16_sel_i, wdata8_i, f_wdata_i, wdata16_i, idu_op_i, idu_tgt_i,
    input  regs_o, idu_addr_o, illegal_o
  );

  modport slave (
    input  wen_i, gp8_sel_i, gp16_sel_i, wdata8_i, f_wdata_i, wdata16_i, idu_op_i, idu_tgt_i,
    output regs_o, idu_addr_o, illegal_o
  );
endinterface

// File: rtl/sm83_regfile_idu.sv
// 16-bit increment/decrement unit; wraps modulo 2^16, passes through on IDU_NONE.
module sm83_idu
  import sm83_pkg::*;
(
  input  logic [15:0] src_i,
  input  idu_op_t     op_i,
  output logic [15:0] res_o
);
  always_comb begin
    case (op_i)
      IDU_INC: res_o = src_i + 16'd1;
      IDU_DEC: res_o = src_i - 16'd1;
      default: res_o = src_i;
    endcase
  end
endmodule

// File: rtl/sm83_regfile.sv
// SM83 architectural register file: write decode, IDU conflict resolution, all state flops.
module sm83_regfile
  import sm83_pkg::*;
#(
  parameter logic [15:0] RST_PC = RST_PC_DEF,
  parameter logic [15:0] RST_SP = RST_SP_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  sm83_regfile_if.slave  bus
);
  reg_vec_t    regs_q, regs_d;
  logic        illegal_q, illegal_d;
  logic [2:0]  sel8;
  logic [1:0]  sel16, gp8_pair;
  logic        gp8_bad, gp8_ok, gp16_bad, gp16_ok;
  logic        idu_on, tgt_ok, idu_cancel, idu_we;
  logic [15:0] idu_src, idu_res;

  // Decode selects and work out whether the IDU may commit this cycle.
  always_comb begin
    sel8       = bus.gp8_sel_i;
    sel16      = bus.gp16_sel_i;
    gp8_bad    = bus.wen_i.gp8 && (sel8 > 3'd5);
    gp8_ok     = bus.wen_i.gp8 && !gp8_bad;
    gp8_pair   = sel8[2:1];
    gp16_bad   = bus.wen_i.gp16 && (sel16 == 2'd3);
    gp16_ok    = bus.wen_i.gp16 && !gp16_bad;
    idu_on     = (bus.idu_op_i == IDU_INC) || (bus.idu_op_i == IDU_DEC);
    idu_src    = 16'h0000;
    tgt_ok     = 1'b0;
    idu_cancel = 1'b0;
    case (bus.idu_tgt_i)
      IDU_PC: begin
        idu_src    = regs_q.pc;
        tgt_ok     = 1'b1;
        idu_cancel = bus.wen_i.pc;
      end
      IDU_SP: begin
        idu_src    = regs_q.sp;
        tgt_ok     = 1'b1;
        idu_cancel = bus.wen_i.sp;
      end
      IDU_R16: begin
        idu_src    = pair_get(regs_q, sel16);
        tgt_ok     = (sel16 != 2'd3);
        idu_cancel = gp16_ok || (gp8_ok && (gp8_pair == sel16));
      end
      default: ;
    endcase
    idu_we    = idu_on && tgt_ok && !idu_cancel;
    illegal_d = gp8_bad || gp16_bad || (idu_on && !tgt_ok);
  end

  sm83_idu u_idu (
    .src_i (idu_src),
    .op_i  (bus.idu_op_i),
    .res_o (idu_res)
  );

  // Apply order: IDU, then byte writes, then pair writes, so wider explicit writes win.
  always_comb begin
    regs_d = regs_q;
    if (bus.wen_i.ir) regs_d.ir = bus.wdata8_i;
    if (bus.wen_i.ie) regs_d.ie = bus.wdata8_i;
    if (bus.wen_i.a)  regs_d.a  = bus.wdata8_i;
    if (bus.wen_i.f)  regs_d.f  = flags_t'(bus.f_wdata_i & 8'hF0);
    if (idu_we) begin
      case (bus.idu_tgt_i)
        IDU_PC: regs_d.pc = idu_res;
        IDU_SP: regs_d.sp = idu_res;
        default: begin
          case (sel16)
            2'd0:    regs_d.b_c.r16 = idu_res;
            2'd1:    regs_d.d_e.r16 = idu_res;
            default: regs_d.h_l.r16 = idu_res;
          endcase
        end
      endcase
    end
    if (gp8_ok) begin
      case (sel8)
        3'd0:    regs_d.b_c.r8.msb = bus.wdata8_i;
        3'd1:    regs_d.b_c.r8.lsb = bus.wdata8_i;
        3'd2:    regs_d.d_e.r8.msb = bus.wdata8_i;
        3'd3:    regs_d.d_e.r8.lsb = bus.wdata8_i;
        3'd4:    regs_d.h_l.r8.msb = bus.wdata8_i;
        default: regs_d.h_l.r8.lsb = bus.wdata8_i;
      endcase
    end
    if (gp16_ok) begin
      case (sel16)
        2'd0:    regs_d.b_c.r16 = bus.wdata16_i;
        2'd1:    regs_d.d_e.r16 = bus.wdata16_i;
        default: regs_d.h_l.r16 = bus.wdata16_i;
      endcase
    end
    if (bus.wen_i.pc) regs_d.pc = bus.wdata16_i;
    if (bus.wen_i.sp) regs_d.sp = bus.wdata16_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '0;
      regs_q.pc <= RST_PC;
      regs_q.sp <= RST_SP;
      illegal_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.regs_o     = regs_q;
  assign bus.idu_addr_o = idu_src;
  assign bus.illegal_o  = illegal_q;

endmodule

// File: tb/tb_sm83_regfile.sv
// Directed bench for sm83_regfile: hand-maintained expected register vector checked after each step.
module tb_sm83_regfile;
  import sm83_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  reg_vec_t exp_r;

  sm83_regfile_if bus ();

  sm83_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus.wen_i      = '0;
    bus.gp8_sel_i  = R8_B;
    bus.gp16_sel_i = R16_BC;
    bus.wdata8_i   = 8'h00;
    bus.f_wdata_i  = '0;
    bus.wdata16_i  = 16'h0000;
    bus.idu_op_i   = IDU_NONE;
    bus.idu_tgt_i  = IDU_PC;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_exp();
    exp_r    = '0;
    exp_r.pc = 16'h0000;
    exp_r.sp = 16'hFFFE;
  endtask

  initial begin
    idle();
    reset_exp();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regs", bus.regs_o, exp_r);
    chk("reset_illegal", bus.illegal_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset asserted while a write of A is pending.
    bus.wen_i.a = 1'b1; bus.wdata8_i = 8'h5A;
    #3 rst_n = 1'b0;
    #1 chk("rst_mid_regs", bus.regs_o, exp_r);
    tick();
    chk("rst_mid_a", bus.regs_o.a, 8'h00);
    idle();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_release", bus.regs_o, exp_r);

    // B then C in consecutive cycles.
    bus.wen_i.gp8 = 1'b1; bus.gp8_sel_i = R8_B; bus.wdata8_i = 8'h12;
    tick(); idle();
    bus.wen_i.gp8 = 1'b1; bus.gp8_sel_i = R8_C; bus.wdata8_i = 8'h34;
    tick(); idle();
    exp_r.b_c.r16 = 16'h1234;
    chk("bc_1234", bus.regs_o.b_c.r16, 16'h1234);
    chk("bc_regs", bus.regs_o, exp_r);

    // PC wrap on increment.
    bus.wen_i.pc = 1'b1; bus.wdata16_i = 16'hFFFF;
    tick(); idle();
    exp_r.pc = 16'hFFFF;
    chk("pc_ffff", bus.regs_o, exp_r);
    bus.idu_op_i = IDU_INC; bus.idu_tgt_i = IDU_PC;
    #1 chk("pc_addr", bus.idu_addr_o, 16'hFFFF);
    tick(); idle();
    exp_r.pc = 16'h0000;
    chk("pc_wrap", bus.regs_o, exp_r);

    // SP wrap on decrement.
    bus.wen_i.sp = 1'b1; bus.wdata16_i = 16'h0000;
    tick(); idle();
    exp_r.sp = 16'h0000;
    bus.idu_op_i = IDU_DEC; bus.idu_tgt_i = IDU_SP;
    #1 chk("sp_addr", bus.idu_addr_o, 16'h0000);
    tick(); idle();
    exp_r.sp = 16'hFFFF;
    chk("sp_wrap", bus.regs_o, exp_r);

    // gp16 write to HL beats IDU on HL.
    bus.wen_i.gp16 = 1'b1; bus.gp16_sel_i = R16_HL; bus.wdata16_i = 16'hABCD;
    bus.idu_op_i = IDU_INC; bus.idu_tgt_i = IDU_R16;
    tick(); idle();
    exp_r.h_l.r16 = 16'hABCD;
    chk("hl_gp16_wins", bus.regs_o, exp_r);

    // Byte write to H cancels IDU on HL.
    bus.wen_i.gp8 = 1'b1; bus.gp8_sel_i = R8_H; bus.wdata8_i = 8'h77;
    bus.gp16_sel_i = R16_HL; bus.idu_op_i = IDU_INC; bus.idu_tgt_i = IDU_R16;
    tick(); idle();
    exp_r.h_l.r16 = 16'h77CD;
    chk("hl_gp8_cancel", bus.regs_o, exp_r);

    // Non-conflicting: B byte write plus IDU on HL.
    bus.wen_i.gp8 = 1'b1; bus.gp8_sel_i = R8_B; bus.wdata8_i = 8'hAA;
    bus.gp16_sel_i = R16_HL; bus.idu_op_i = IDU_INC; bus.idu_tgt_i = IDU_R16;
    tick(); idle();
    exp_r.b_c.r16 = 16'hAA34;
    exp_r.h_l.r16 = 16'h77CE;
    chk("b_plus_idu_hl", bus.regs_o, exp_r);

    // Explicit SP write cancels IDU on SP.
    bus.wen_i.sp = 1'b1; bus.wdata16_i = 16'h1000;
    bus.idu_op_i = IDU_DEC; bus.idu_tgt_i = IDU_SP;
    tick(); idle();
    exp_r.sp = 16'h1000;
    chk("sp_write_wins", bus.regs_o, exp_r);

    // F low nibble forced to zero; IR/IE/A in one cycle.
    bus.wen_i.f = 1'b1; bus.f_wdata_i = flags_t'(8'hFF);
    bus.wen_i.ir = 1'b1; bus.wen_i.ie = 1'b1; bus.wen_i.a = 1'b1; bus.wdata8_i = 8'h3C;
    tick(); idle();
    exp_r.f  = flags_t'(8'hF0);
    exp_r.ir = 8'h3C; exp_r.ie = 8'h3C; exp_r.a = 8'h3C;
    chk("f_low_zero", bus.regs_o.f, 8'hF0);
    chk("f_ir_ie_a", bus.regs_o, exp_r);

    // Out-of-range gp8 select: dropped, one-cycle illegal pulse.
    bus.wen_i.gp8 = 1'b1; bus.gp8_sel_i = gp_r8_sel_t'(3'd6); bus.wdata8_i = 8'h99;
    tick(); idle();
    chk("gp8_bad_regs", bus.regs_o, exp_r);
    chk("gp8_bad_ill", bus.illegal_o, 1'b1);
    tick();
    chk("gp8_bad_pulse", bus.illegal_o, 1'b0);

    // Out-of-range gp16 select.
    bus.wen_i.gp16 = 1'b1; bus.gp16_sel_i = gp_r16_sel_t'(2'd3); bus.wdata16_i = 16'h5555;
    tick(); idle();
    chk("gp16_bad_regs", bus.regs_o, exp_r);
    chk("gp16_bad_ill", bus.illegal_o, 1'b1);

    // IDU_R16 with select 3, then reserved IDU target.
    bus.gp16_sel_i = gp_r16_sel_t'(2'd3); bus.idu_op_i = IDU_INC; bus.idu_tgt_i = IDU_R16;
    tick(); idle();
    chk("idu_r16_bad_regs", bus.regs_o, exp_r);
    chk("idu_r16_bad_ill", bus.illegal_o, 1'b1);
    bus.idu_op_i = IDU_INC; bus.idu_tgt_i = idu_tgt_t'(2'd3);
    tick(); idle();
    chk("idu_tgt3_regs", bus.regs_o, exp_r);
    chk("idu_tgt3_ill", bus.illegal_o, 1'b1);
    tick();
    chk("illegal_clear", bus.illegal_o, 1'b0);

    // Address bus source valid with IDU_NONE.
    bus.idu_tgt_i = IDU_SP;
    #1 chk("addr_none_sp", bus.idu_addr_o, 16'h1000);
    bus.idu_tgt_i = IDU_R16; bus.gp16_sel_i = R16_BC;
    #1 chk("addr_none_bc", bus.idu_addr_o, 16'hAA34);
    tick(); idle();
    chk("none_no_change", bus.regs_o, exp_r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
